// File: rtl/example_arb_pkg.sv
// Shared types and the round-robin pick function for the example core arbiter.
package example_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned MAX_REQ = 16;

  // One-hot winner: first set bit of valid searching from last+1 upward, wrapping at n-1 -> 0.
  function automatic logic [MAX_REQ-1:0] rr_next(
    input logic [MAX_REQ-1:0] valid,
    input logic [3:0]         last,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [31:0]        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = (32'(last) + 32'(i)) % n;
      if (!found && (i <= n) && valid[idx[3:0]]) begin
        gnt[idx[3:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/example_core_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant and its index from a request vector.
module example_rr_arbiter
  import example_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_REQ-1:0] gnt_ext_s;
  logic [3:0]         last_ext_s;

  // Widen to the package's fixed width, pick, then encode the one-hot grant.
  always_comb begin
    req_ext_s                = '0;
    req_ext_s[NUM_REQ-1:0]   = req_i;
    last_ext_s               = 4'd0;
    last_ext_s[ID_W-1:0]     = last_i;
    gnt_ext_s                = rr_next(req_ext_s, last_ext_s, NUM_REQ);
    gnt_o                    = gnt_ext_s[NUM_REQ-1:0];
    idx_o                    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_o = idx_o | (ID_W'(i) & {ID_W{gnt_o[i]}});
    end
  end

endmodule

// File: rtl/example_core_arbiter.sv
// Round-robin front end sharing one core between NUM_REQ requesters, one transaction at a time.
// Optional core watchdog enabled by defining EXAMPLE_ARB_TIMEOUT_EN.
module example_core_arbiter
  import example_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_err_o,
  output logic                          core_req_o,
  output logic [DATA_WIDTH-1:0]         core_data_o,
  input  logic [DATA_WIDTH-1:0]         core_data_i,
  input  logic                          core_valid_i,
  output logic                          busy_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]    gnt_s;
  logic [ID_W-1:0]       gnt_idx_s;
  logic [DATA_WIDTH-1:0] sel_op_s;
  logic                  expire_s;

  example_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (gnt_s),
    .idx_o  (gnt_idx_s)
  );

  // Operand of the winner; grant is one-hot so an AND-OR mux suffices.
  always_comb begin
    sel_op_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_op_s = sel_op_s | ({DATA_WIDTH{gnt_s[k]}} & req_data_i[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

`ifdef EXAMPLE_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             rsp_err_q, rsp_err_d;

  // Expires on the TIMEOUT_CYCLES-th WAIT cycle, i.e. when the count would reach the limit.
  always_comb begin
    expire_s = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    if (state_q == ISSUE) begin
      wait_cnt_d = '0;
    end else if (state_q == WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Watchdog counter and error flag registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_err_o = rsp_err_q;
`else
  assign expire_s  = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    op_d       = op_q;
    rsp_data_d = rsp_data_q;
`ifdef EXAMPLE_ARB_TIMEOUT_EN
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|gnt_s) begin
          id_d    = gnt_idx_s;
          op_d    = sel_op_s;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        last_d  = id_q;
        state_d = WAIT;
      end
      WAIT: begin
        // A core result in the expiry cycle still wins over the timeout.
        if (core_valid_i) begin
          rsp_data_d = core_data_i;
`ifdef EXAMPLE_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = RESP;
        end else if (expire_s) begin
          rsp_data_d = '0;
`ifdef EXAMPLE_ARB_TIMEOUT_EN
          rsp_err_d  = 1'b1;
`endif
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; last_q starts at NUM_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      last_q     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      id_q       <= id_d;
      op_q       <= op_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Grant is masked by reset so req_ready_o is quiet while rst_n_i is low.
  always_comb begin
    if ((state_q == IDLE) && rst_n_i) begin
      req_ready_o = gnt_s;
    end else begin
      req_ready_o = '0;
    end
  end

  assign core_req_o  = (state_q == ISSUE);
  assign core_data_o = op_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != IDLE);

endmodule
